// File: rtl/sramlike_port_bridge.sv
// Bridges a single-cycle SRAM-style CPU port onto a split-transaction sram-like bus
// (req/addr_ok/data_ok), with per-port stall, read-data hold, flush handling and a stall counter.
module sramlike_port_bridge #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_en,
   input  logic [DATA_W/8-1:0]   cpu_wen,
   input  logic [1:0]            cpu_size,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  ext_stall,
   input  logic                  flush,
   output logic                  req,
   output logic                  wr,
   output logic [1:0]            size,
   output logic [ADDR_W-1:0]     addr,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   input  logic                  addr_ok,
   input  logic [DATA_W-1:0]     rdata,
   input  logic                  data_ok,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} state_t;

   state_t              state, state_nx;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [STRB_W-1:0]   lat_wstrb;
   logic [1:0]          lat_size;
   logic                lat_wr;
   logic [DATA_W-1:0]   rdata_buf;
   logic                issue;
   logic                take_data;

   always_comb begin
      state_nx  = state;
      req       = 1'b0;
      cpu_stall = 1'b0;
      wr        = lat_wr;
      size      = lat_size;
      addr      = lat_addr;
      wdata     = lat_wdata;
      wstrb     = lat_wstrb;
      cpu_rdata = rdata_buf;
      take_data = 1'b0;
      issue     = cpu_en & ~flush;
      case (state)
         IDLE: begin
            // Zero-bubble issue: bus fields come straight from the CPU this cycle.
            wr        = |cpu_wen;
            size      = cpu_size;
            addr      = cpu_addr;
            wdata     = cpu_wdata;
            wstrb     = cpu_wen;
            req       = issue;
            cpu_stall = issue;
            if (issue && addr_ok)
               state_nx = WAIT;
            else if (issue)
               state_nx = REQ;
         end
         REQ: begin
            cpu_stall = 1'b1;
            if (flush) begin
               state_nx = IDLE;
            end else begin
               req = 1'b1;
               if (addr_ok)
                  state_nx = WAIT;
            end
         end
         WAIT: begin
            if (data_ok) begin
               take_data = 1'b1;
               cpu_rdata = rdata;
               state_nx  = ext_stall ? HOLD : IDLE;
            end else begin
               cpu_stall = 1'b1;
               if (flush)
                  state_nx = DISCARD;
            end
         end
         HOLD: begin
            if (!ext_stall || flush)
               state_nx = IDLE;
         end
         DISCARD: begin
            if (data_ok)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         lat_size  <= '0;
         lat_wr    <= 1'b0;
         rdata_buf <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && cpu_en) begin
            lat_addr  <= cpu_addr;
            lat_wdata <= cpu_wdata;
            lat_wstrb <= cpu_wen;
            lat_size  <= cpu_size;
            lat_wr    <= |cpu_wen;
         end
         if (take_data)
            rdata_buf <= rdata;
         if (cpu_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_sramlike_port_bridge.sv
// Bench for sramlike_port_bridge: directed cycle table, hand-written reset/saturation sequences,
// and randomized traffic checked against a transaction-level model of the port.
module tb_sramlike_port_bridge;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 10;
   localparam int unsigned SW = DW / 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            cpu_en;
   logic [SW-1:0]   cpu_wen;
   logic [1:0]      cpu_size;
   logic [AW-1:0]   cpu_addr;
   logic [DW-1:0]   cpu_wdata;
   logic [DW-1:0]   cpu_rdata;
   logic            cpu_stall;
   logic            ext_stall;
   logic            flush;
   logic            req;
   logic            wr;
   logic [1:0]      size;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [SW-1:0]   wstrb;
   logic            addr_ok;
   logic [DW-1:0]   rdata;
   logic            data_ok;
   logic [CW-1:0]   stall_cnt;

   always #5 clk = ~clk;

   sramlike_port_bridge #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_stall(ext_stall), .flush(flush), .req(req), .wr(wr), .size(size), .addr(addr),
      .wdata(wdata), .wstrb(wstrb), .addr_ok(addr_ok), .rdata(rdata), .data_ok(data_ok),
      .stall_cnt(stall_cnt)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] en, wen, sz, a, wd, xs, fl, aok, dok, rd;
      logic [31:0] e_req, e_stall, e_rdata, e_cnt, e_addr, e_wstrb, e_sz, e_wdata;
   } vec_t;

   vec_t tv [25];

   task automatic idle_inputs();
      cpu_en = 1'b0; cpu_wen = '0; cpu_size = 2'd2; cpu_addr = '0; cpu_wdata = '0;
      ext_stall = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
   endtask

   // Transaction-level reference state
   logic          m_pend, m_outst, m_dead, m_hold;
   logic [DW-1:0] m_buf;
   logic [CW-1:0] m_cnt;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [SW-1:0] m_wstrb;
   logic [1:0]    m_size;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // cols: en wen sz addr wdata xs fl aok dok rdata | req stall rdata cnt | addr wstrb sz wdata
      tv[0]  = '{1, 0, 2, 'h100, 0, 0, 0, 1, 0, 0,            1, 1, 0, 0,                     'h100, 0, 2, 0};
      tv[1]  = '{1, 0, 2, 'h100, 0, 0, 0, 0, 0, 0,            0, 1, 0, 1,                     0, 0, 0, 0};
      tv[2]  = '{1, 0, 2, 'h100, 0, 0, 0, 0, 1, 'hDEADBEEF,   0, 0, 'hDEADBEEF, 2,            0, 0, 0, 0};
      tv[3]  = '{1, 3, 1, 'h10000004, 'hCAFEF00D, 0, 0, 0, 0, 0, 1, 1, 'hDEADBEEF, 2,      'h10000004, 3, 1, 'hCAFEF00D};
      tv[4]  = '{1, 0, 2, 'hFFFF0000, 0, 0, 0, 0, 0, 0,       1, 1, 'hDEADBEEF, 3,            'h10000004, 3, 1, 'hCAFEF00D};
      tv[5]  = '{1, 0, 2, 'hFFFF0000, 0, 0, 0, 0, 0, 0,       1, 1, 'hDEADBEEF, 4,            'h10000004, 3, 1, 'hCAFEF00D};
      tv[6]  = '{1, 0, 2, 'hFFFF0000, 0, 0, 0, 1, 0, 0,       1, 1, 'hDEADBEEF, 5,            'h10000004, 3, 1, 'hCAFEF00D};
      tv[7]  = '{0, 0, 2, 0, 0, 0, 0, 0, 0, 0,                0, 1, 'hDEADBEEF, 6,            0, 0, 0, 0};
      tv[8]  = '{0, 0, 2, 0, 0, 0, 0, 0, 1, 0,                0, 0, 0, 7,                     0, 0, 0, 0};
      tv[9]  = '{1, 0, 2, 'h200, 0, 0, 0, 1, 0, 0,            1, 1, 0, 7,                     'h200, 0, 2, 0};
      tv[10] = '{1, 0, 2, 'h200, 0, 0, 0, 0, 0, 0,            0, 1, 0, 8,                     0, 0, 0, 0};
      tv[11] = '{1, 0, 2, 'h200, 0, 1, 0, 0, 1, 'h12345678,   0, 0, 'h12345678, 9,            0, 0, 0, 0};
      tv[12] = '{1, 0, 2, 'h300, 0, 1, 0, 1, 0, 0,            0, 0, 'h12345678, 9,            0, 0, 0, 0};
      tv[13] = '{1, 0, 2, 'h300, 0, 1, 0, 1, 0, 0,            0, 0, 'h12345678, 9,            0, 0, 0, 0};
      tv[14] = '{1, 0, 2, 'h300, 0, 1, 0, 1, 0, 0,            0, 0, 'h12345678, 9,            0, 0, 0, 0};
      tv[15] = '{1, 0, 2, 'h300, 0, 0, 0, 0, 0, 0,            0, 0, 'h12345678, 9,            0, 0, 0, 0};
      tv[16] = '{1, 0, 2, 'h300, 0, 0, 0, 0, 0, 0,            1, 1, 'h12345678, 9,            'h300, 0, 2, 0};
      tv[17] = '{1, 0, 2, 'h300, 0, 0, 1, 0, 0, 0,            0, 1, 'h12345678, 10,           0, 0, 0, 0};
      tv[18] = '{0, 0, 2, 0, 0, 0, 0, 0, 0, 0,                0, 0, 'h12345678, 11,           0, 0, 0, 0};
      tv[19] = '{1, 0, 2, 'h400, 0, 0, 0, 1, 0, 0,            1, 1, 'h12345678, 11,           'h400, 0, 2, 0};
      tv[20] = '{0, 0, 2, 0, 0, 0, 1, 0, 0, 0,                0, 1, 'h12345678, 12,           0, 0, 0, 0};
      tv[21] = '{1, 0, 2, 'h500, 0, 0, 0, 0, 0, 0,            0, 0, 'h12345678, 13,           0, 0, 0, 0};
      tv[22] = '{1, 0, 2, 'h500, 0, 0, 0, 0, 1, 'hAAAA5555,   0, 0, 'h12345678, 13,           0, 0, 0, 0};
      tv[23] = '{1, 0, 2, 'h500, 0, 0, 0, 0, 0, 0,            1, 1, 'h12345678, 13,           'h500, 0, 2, 0};
      tv[24] = '{1, 0, 2, 'h500, 0, 0, 0, 1, 0, 0,            1, 1, 'h12345678, 14,           'h500, 0, 2, 0};

      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_req", req, 0);
      chk("reset_stall", cpu_stall, 0);
      chk("reset_rdata", cpu_rdata, 0);
      chk("reset_cnt", stall_cnt, 0);
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         cpu_en = tv[i].en[0]; cpu_wen = tv[i].wen[SW-1:0]; cpu_size = tv[i].sz[1:0];
         cpu_addr = tv[i].a[AW-1:0]; cpu_wdata = tv[i].wd[DW-1:0]; ext_stall = tv[i].xs[0];
         flush = tv[i].fl[0]; addr_ok = tv[i].aok[0]; data_ok = tv[i].dok[0]; rdata = tv[i].rd[DW-1:0];
         #1;
         chk($sformatf("tv%0d_req", i), req, tv[i].e_req);
         chk($sformatf("tv%0d_stall", i), cpu_stall, tv[i].e_stall);
         chk($sformatf("tv%0d_rdata", i), cpu_rdata, tv[i].e_rdata);
         chk($sformatf("tv%0d_cnt", i), stall_cnt, tv[i].e_cnt);
         if (tv[i].e_req[0]) begin
            chk($sformatf("tv%0d_addr", i), addr, tv[i].e_addr);
            chk($sformatf("tv%0d_wdata", i), wdata, tv[i].e_wdata);
            chk($sformatf("tv%0d_ctl", i), {wr, size, wstrb},
                {|tv[i].e_wstrb[SW-1:0], tv[i].e_sz[1:0], tv[i].e_wstrb[SW-1:0]});
         end
      end

      // Reset while a read is outstanding, then a stray data_ok must be ignored.
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_wait_req", req, 0);
      chk("rst_wait_stall", cpu_stall, 0);
      chk("rst_wait_rdata", cpu_rdata, 0);
      chk("rst_wait_cnt", stall_cnt, 0);
      @(negedge clk);
      data_ok = 1'b1; rdata = 32'hFFFFFFFF;
      #1;
      chk("stray_dok_rdata", cpu_rdata, 0);
      chk("stray_dok_stall", cpu_stall, 0);
      @(negedge clk);
      data_ok = 1'b0;
      #1;
      chk("stray_dok_buf", cpu_rdata, 0);

      // Stall counter saturation: park in REQ without acceptance.
      @(negedge clk);
      cpu_en = 1'b1; cpu_addr = 32'h600;
      for (int i = 0; i < (1 << CW) + 5; i++) @(negedge clk);
      #1;
      chk("sat_cnt", stall_cnt, {CW{1'b1}});
      chk("sat_req", req, 1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      chk("sat_hold_cnt", stall_cnt, {CW{1'b1}});
      chk("sat_flush_req", req, 0);

      // Randomized traffic against the transaction-level model.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_pend = 0; m_outst = 0; m_dead = 0; m_hold = 0; m_buf = '0; m_cnt = '0;
      m_addr = '0; m_wdata = '0; m_wstrb = '0; m_size = '0;
      for (int c = 0; c < 3000; c++) begin
         logic          e_req, e_stall;
         logic [DW-1:0] e_rdata;
         logic [AW-1:0] ea;
         logic [DW-1:0] ed;
         logic [SW-1:0] ew;
         logic [1:0]    ez;
         @(negedge clk);
         cpu_en    = ($urandom_range(0, 3) != 0);
         cpu_wen   = ($urandom_range(0, 1) != 0) ? '0 : SW'($urandom);
         cpu_size  = 2'($urandom_range(0, 2));
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         ext_stall = ($urandom_range(0, 2) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         addr_ok   = ($urandom_range(0, 1) != 0);
         data_ok   = m_outst && ($urandom_range(0, 2) == 0);
         rdata     = $urandom;
         #1;
         e_req = 0; e_stall = 0; e_rdata = m_buf;
         ea = m_addr; ed = m_wdata; ew = m_wstrb; ez = m_size;
         if (m_hold) begin
            if (!ext_stall || flush) m_hold = 0;
         end else if (m_outst) begin
            if (data_ok) begin
               m_outst = 0;
               if (!m_dead) begin
                  e_rdata = rdata;
                  m_buf   = rdata;
                  m_hold  = ext_stall;
               end
            end else begin
               e_stall = !m_dead;
               if (flush) m_dead = 1;
            end
         end else if (m_pend) begin
            e_stall = 1;
            if (flush) begin
               m_pend = 0;
            end else begin
               e_req = 1;
               if (addr_ok) begin
                  m_pend = 0; m_outst = 1; m_dead = 0;
               end
            end
         end else if (cpu_en && !flush) begin
            e_req = 1; e_stall = 1;
            ea = cpu_addr; ed = cpu_wdata; ew = cpu_wen; ez = cpu_size;
            if (addr_ok) begin
               m_outst = 1; m_dead = 0;
            end else begin
               m_pend = 1;
               m_addr = cpu_addr; m_wdata = cpu_wdata; m_wstrb = cpu_wen; m_size = cpu_size;
            end
         end
         chk("rnd_req", req, e_req);
         chk("rnd_stall", cpu_stall, e_stall);
         chk("rnd_rdata", cpu_rdata, e_rdata);
         chk("rnd_cnt", stall_cnt, m_cnt);
         if (e_req) begin
            chk("rnd_addr", addr, ea);
            chk("rnd_wdata", wdata, ed);
            chk("rnd_ctl", {wr, size, wstrb}, {|ew, ez, ew});
         end
         if (e_stall && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
